// File: rtl/noc_pkg.sv
// Shared NoC definitions: flit layout, flit type codes and transmitter states.
package noc_pkg;

  localparam int FLIT_W    = 16;
  localparam int PAYLOAD_W = 14;
  localparam int COORD_W   = 4;
  localparam int LEN_W     = 4;

  localparam int TYPE_HI = 15;
  localparam int TYPE_LO = 14;
  localparam int DX_HI   = 13;
  localparam int DX_LO   = 10;
  localparam int DY_HI   = 9;
  localparam int DY_LO   = 6;
  localparam int LEN_HI  = 5;
  localparam int LEN_LO  = 2;

  typedef enum logic [1:0] {
    FT_NONE = 2'b00,
    FT_HEAD = 2'b01,
    FT_BODY = 2'b10,
    FT_TAIL = 2'b11
  } flit_type_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_HEAD = 2'b01,
    ST_BODY = 2'b10
  } tx_state_e;

  function automatic logic [FLIT_W-1:0] make_head(
    input logic [COORD_W-1:0] dx,
    input logic [COORD_W-1:0] dy,
    input logic [LEN_W-1:0]   len
  );
    return {FT_HEAD, dx, dy, len, 2'b00};
  endfunction

  function automatic logic [FLIT_W-1:0] make_payload(
    input flit_type_e             ftype,
    input logic [PAYLOAD_W-1:0]   word
  );
    return {ftype, word};
  endfunction

endpackage

// File: rtl/flit_fifo.sv
// Small synchronous FIFO for payload words; pointers wrap modulo DEPTH (power of 2).
module flit_fifo #(
  parameter int WIDTH = 14,
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  // A full FIFO still takes a word when one leaves in the same cycle.
  assign do_push = push && (!full || pop);
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  // NOTE: storage carries no reset; the reset pointers/count make stale entries unreachable.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      unique case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/local_flit_tx.sv
// Network-interface transmitter: turns a header plus payload words into head/body/tail
// flits for a router input port, paced by credit-based flow control.
module local_flit_tx
  import noc_pkg::*;
#(
  parameter  int CREDITS    = 4,
  parameter  int FIFO_DEPTH = 4,
  localparam int CRED_W     = $clog2(CREDITS + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 pkt_valid_i,
  output logic                 pkt_ready_o,
  input  logic [COORD_W-1:0]   dest_x_i,
  input  logic [COORD_W-1:0]   dest_y_i,
  input  logic [LEN_W-1:0]     pkt_len_i,
  input  logic                 word_valid_i,
  output logic                 word_ready_o,
  input  logic [PAYLOAD_W-1:0] word_i,
  output logic [FLIT_W-1:0]    flit_o,
  input  logic                 iner_i,
  output logic [CRED_W-1:0]    credit_o,
  output logic                 busy_o,
  output logic                 cred_err_o
);

  localparam int FCNT_W = $clog2(FIFO_DEPTH + 1);

  tx_state_e              state, state_nxt;
  logic [COORD_W-1:0]     hdr_dx, hdr_dy;
  logic [LEN_W-1:0]       hdr_len;
  logic [LEN_W-1:0]       remaining;
  logic                   send_head, send_body, send, is_tail;
  logic [PAYLOAD_W-1:0]   fifo_rdata;
  logic                   fifo_full, fifo_empty;
  logic [FCNT_W-1:0]      fifo_count;

  flit_fifo #(.WIDTH(PAYLOAD_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (word_valid_i && word_ready_o),
    .pop   (send_body),
    .wdata (word_i),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE: if (pkt_valid_i) state_nxt = ST_HEAD;
      ST_HEAD: if (send_head)   state_nxt = (hdr_len == '0) ? ST_IDLE : ST_BODY;
      ST_BODY: if (send_body && is_tail) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Sends only on credit already held; a same-cycle iner_i cannot fund a send.
  always_comb begin
    pkt_ready_o  = (state == ST_IDLE);
    busy_o       = (state != ST_IDLE);
    word_ready_o = !fifo_full;
    send_head    = (state == ST_HEAD) && (credit_o != '0);
    send_body    = (state == ST_BODY) && (credit_o != '0) && !fifo_empty;
    send         = send_head || send_body;
    is_tail      = (remaining == LEN_W'(1));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hdr_dx     <= '0;
      hdr_dy     <= '0;
      hdr_len    <= '0;
      remaining  <= '0;
      flit_o     <= '0;
      credit_o   <= CRED_W'(CREDITS);
      cred_err_o <= 1'b0;
    end else begin
      if (pkt_valid_i && pkt_ready_o) begin
        hdr_dx  <= dest_x_i;
        hdr_dy  <= dest_y_i;
        hdr_len <= pkt_len_i;
      end

      if (send_head)      remaining <= hdr_len;
      else if (send_body) remaining <= remaining - LEN_W'(1);

      if (send_head)      flit_o <= make_head(hdr_dx, hdr_dy, hdr_len);
      else if (send_body) flit_o <= make_payload(is_tail ? FT_TAIL : FT_BODY, fifo_rdata);
      else                flit_o <= '0;

      unique case ({send, iner_i})
        2'b10: credit_o <= credit_o - CRED_W'(1);
        2'b01: begin
          if (credit_o == CRED_W'(CREDITS)) cred_err_o <= 1'b1;
          else                              credit_o   <= credit_o + CRED_W'(1);
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) assert (fifo_count <= FCNT_W'(FIFO_DEPTH));
  end

endmodule
